calc_sequencer: RTL
===================

Name: calc_sequencer

Overview:
- Control FSM for the keypad calculator's operand/operator capture block.
- Generates that block's 2-bit entry-phase code `estado`, and gates and forwards keypad presses into it.
- Counts entered digits and launches the ALU with a start/done handshake, plus a watchdog timeout.
- Sits between the keypad decoder (boton/valor) and the operand block + ALU.

Parameters:
- HEX_DIGITS, 4: maximum digits accepted per operand when mode=0 (hex).
- DEC_DIGITS, 5: maximum digits accepted per operand when mode=1 (decimal).
- TIMEOUT, 255: cycles allowed from alu_start to alu_done before the error state.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- boton  in  1  one-cycle key-press strobe from the keypad decoder
- valor  in  5  key code: 0x00-0x0F digit, 0x13 EXE, 0x16 CE, 0x17 AC, other >0x0F operator
- mode  in  1  0 = hex entry, 1 = decimal entry
- operador  in  5  operator currently held by the operand block; 0x18 = none
- alu_done  in  1  ALU result-ready pulse
- alu_err  in  1  ALU error flag, sampled with alu_done
- estado  out  2  phase code to the operand block: 0 = op1, 1 = op2, 2 = operator, 3 = result
- boton_fwd  out  1  gated key strobe to the operand block (combinational)
- valor_fwd  out  5  valor passed through unchanged
- alu_start  out  1  one-cycle ALU launch pulse
- busy  out  1  high in EXEC
- err  out  1  high in ERROR
- digit_cnt  out  3  digits accepted in the current operand

Behaviour:
- Reset sets:
  - state OP1; estado = 0
  - alu_start = 0, busy = 0, err = 0, digit_cnt = 0
  - timer = 0
- Reset mid-EXEC abandons the computation; no alu_start is issued afterwards.
- States and estado encoding: OP1 = 0, OP2 = 1, OPR = 2, EXEC = 2, SHOW = 3, ERROR = 3.
- All state, estado and counter updates are registered.
  - A key pressed in cycle N is forwarded with the estado of cycle N.
  - Its transition is visible at cycle N+1.
- Limit = HEX_DIGITS if mode = 0, else DEC_DIGITS, evaluated per press.
- OP1/OP2:
  - Digit press with digit_cnt < limit: forward it; digit_cnt + 1.
  - Digit press with digit_cnt >= limit: not forwarded; count unchanged.
  - CE: forward; digit_cnt = 0.
  - EXE: forward; advance OP1->OP2 or OP2->OPR; digit_cnt = 0.
  - Operator keys: not forwarded.
- OPR:
  - Operator and CE presses are forwarded.
  - Digits are not forwarded.
  - EXE with operador != 0x18 and no operator press in the same cycle: EXE not forwarded; alu_start = 1 for exactly the next cycle; enter EXEC; timer cleared.
  - EXE with operador == 0x18: ignored; stay in OPR.
- EXEC:
  - busy = 1. All keys are blocked except AC.
  - Timer increments every cycle.
  - alu_done with alu_err = 0 -> SHOW.
  - alu_done with alu_err = 1 -> ERROR.
  - Timer reaching TIMEOUT with no alu_done -> ERROR.
  - alu_done in the same cycle as timeout: done wins.
- SHOW:
  - EXE: forwarded (the operand block clears on it); next state OP1; digit_cnt = 0.
  - All other keys except AC are blocked.
- ERROR:
  - err = 1.
  - EXE or AC: forward, -> OP1; err clears next cycle.
- AC (0x17) in any state: forwarded; next state OP1; digit_cnt = 0.
  - Aborts EXEC; a late alu_done is then ignored.
  - AC takes priority over every other transition.
- alu_done outside EXEC is ignored.
- boton = 0: boton_fwd = 0, and no key-driven transition occurs.

Optional Feature:
- Macro AUTO_ADVANCE_EN.
- Defined:
  - In OP1/OP2, when an accepted digit makes digit_cnt equal to the limit, the state advances (OP1->OP2, OP2->OPR) in the same registered update.
  - digit_cnt resets to 0 on that advance.
  - No EXE press is needed.
- Undefined: advance only on EXE; excess digits are dropped as above.

Test Plan:
- Reset then hex entry of digits 1, 2, 3, 4, 5 -> digits 1-4 produce boton_fwd pulses, digit_cnt = 4; digit 5 not forwarded; estado stays 0.
- EXE in OP1, EXE in OP2, operator 0x10 in OPR, EXE with operador = 0x10 -> estado 0→1→2; alu_start pulse one cycle after the final EXE; busy = 1; alu_done 3 cycles later -> estado = 3, busy = 0.
- EXE in OPR with operador = 0x18 -> no alu_start; estado stays 2.
- In EXEC, hold alu_done low for TIMEOUT = 255 cycles -> err = 1, estado = 3; EXE press -> estado = 0, err = 0.
- AC pressed during EXEC, then alu_done arrives -> estado = 0, no SHOW, alu_done ignored; reset asserted in SHOW -> estado = 0 next cycle.
- mode = 1, six digit presses in OP2 -> 5 accepted; with AUTO_ADVANCE_EN, estado becomes 2 after the 5th accepted digit and the 6th is not forwarded as a digit.

Source files
------------

// File: rtl/calc_sequencer.sv
// Entry-phase sequencer for the keypad calculator: gates key presses, counts digits, launches the ALU.
// Optional macro AUTO_ADVANCE_EN: a digit that fills the operand advances the phase without EXE.
module calc_sequencer #(
  parameter int HEX_DIGITS = 4,
  parameter int DEC_DIGITS = 5,
  parameter int TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       boton,
  input  logic [4:0] valor,
  input  logic       mode,
  input  logic [4:0] operador,
  input  logic       alu_done,
  input  logic       alu_err,
  output logic [1:0] estado,
  output logic       boton_fwd,
  output logic [4:0] valor_fwd,
  output logic       alu_start,
  output logic       busy,
  output logic       err,
  output logic [2:0] digit_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {OP1, OP2, OPR, EXEC, SHOW, ERROR} state_t;

  state_t          state_reg, state_next;
  logic [2:0]      cnt_reg, cnt_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic            start_reg, start_next;
  logic            fwd;
  logic [2:0]      limit;
  logic            is_digit, is_exe, is_ce, is_ac, is_op;
  state_t          phase_adv;

  assign is_digit  = (valor <= 5'h0F);
  assign is_exe    = (valor == 5'h13);
  assign is_ce     = (valor == 5'h16);
  assign is_ac     = (valor == 5'h17);
  assign is_op     = !is_digit && !is_exe && !is_ce && !is_ac;
  assign limit     = mode ? 3'(DEC_DIGITS) : 3'(HEX_DIGITS);
  assign phase_adv = (state_reg == OP1) ? OP2 : OPR;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= OP1;
      cnt_reg   <= 3'd0;
      timer_reg <= '0;
      start_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      timer_reg <= timer_next;
      start_reg <= start_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    timer_next = timer_reg;
    start_next = 1'b0;
    fwd        = 1'b0;
    // AC overrides everything, including a pending ALU result
    if (boton && is_ac) begin
      fwd        = 1'b1;
      state_next = OP1;
      cnt_next   = 3'd0;
    end else begin
      case (state_reg)
        OP1, OP2: begin
          if (boton) begin
            if (is_digit) begin
              if (cnt_reg < limit) begin
                fwd      = 1'b1;
                cnt_next = cnt_reg + 3'd1;
`ifdef AUTO_ADVANCE_EN
                if (cnt_reg + 3'd1 == limit) begin
                  state_next = phase_adv;
                  cnt_next   = 3'd0;
                end
`endif
              end
            end else if (is_ce) begin
              fwd      = 1'b1;
              cnt_next = 3'd0;
            end else if (is_exe) begin
              fwd        = 1'b1;
              state_next = phase_adv;
              cnt_next   = 3'd0;
            end
          end
        end
        OPR: begin
          if (boton) begin
            if (is_op || is_ce) begin
              fwd = 1'b1;
            end else if (is_exe && operador != 5'h18) begin
              start_next = 1'b1;
              state_next = EXEC;
              timer_next = '0;
            end
          end
        end
        EXEC: begin
          timer_next = timer_reg + 1'b1;
          if (alu_done) begin
            state_next = alu_err ? ERROR : SHOW;
          end else if (timer_reg == TW'(TIMEOUT - 1)) begin
            state_next = ERROR;
          end
        end
        SHOW, ERROR: begin
          if (boton && is_exe) begin
            fwd        = 1'b1;
            state_next = OP1;
            cnt_next   = 3'd0;
          end
        end
        default: state_next = OP1;
      endcase
    end
  end

  always_comb begin
    case (state_reg)
      OP1:         estado = 2'd0;
      OP2:         estado = 2'd1;
      OPR, EXEC:   estado = 2'd2;
      default:     estado = 2'd3;
    endcase
  end

  assign boton_fwd = fwd;
  assign valor_fwd = valor;
  assign alu_start = start_reg;
  assign busy      = (state_reg == EXEC);
  assign err       = (state_reg == ERROR);
  assign digit_cnt = cnt_reg;

endmodule
